// File: rtl/ps2_keypad_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keypad_rx
// Purpose  : PS/2 keyboard receiver. Turns scan codes into a held key value
//            for the alarm controller, with a 4-deep FIFO and minimum hold.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keypad_rx #(
    parameter int MIN_HOLD = 400000,
    parameter int TIMEOUT  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int TO_W   = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Synchronizers and edge detect
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       fall;
    logic       rx_bit;

    assign fall   = clk_prev_q & ~clk_sync_q[1];
    assign rx_bit = data_sync_q[1];

    // Receiver
    rx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              byte_stb_q, byte_stb_d;
    logic              frame_err_q, frame_err_d;

    // Decoder
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic              enq;
    logic [7:0]        enq_data;

    // FIFO and key hold
    logic [7:0]        mem_q [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        key_q, key_d;
    logic              key_valid_q;
    logic              overrun_q, overrun_d;
    logic              pop;
    logic              push;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;

        // A stalled keyboard mid-frame drops us back to IDLE
        if (state_q == RX_IDLE) begin
            to_cnt_d = '0;
        end else if (!fall) begin
            if (to_cnt_q == TO_LAST) begin
                state_d     = RX_IDLE;
                frame_err_d = 1'b1;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                RX_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = rx_bit;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (rx_bit && (^{shift_q, par_q})) begin
                        byte_stb_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // A break prefix turns the following code into a "no key" release
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        enq      = 1'b0;
        enq_data = 8'h00;
        if (byte_stb_q) begin
            if (brk_q) begin
                enq      = 1'b1;
                enq_data = 8'h00;
                brk_d    = 1'b0;
                ext_d    = 1'b0;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d    = 1'b1;
                enq      = 1'b1;
                enq_data = 8'hF0;
            end else begin
                enq      = 1'b1;
                enq_data = shift_q;
                ext_d    = 1'b0;
            end
        end
    end

    // Pop is served first, so a full FIFO still takes a write on a pop cycle
    always_comb begin
        pop       = (count_q != 3'd0) && (hold_q == '0);
        push      = enq && ((count_q != 3'd4) || pop);
        overrun_d = enq && !push;
        wr_ptr_d  = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d   = count_q + {2'b00, push} - {2'b00, pop};
        key_d     = pop ? mem_q[rd_ptr_q] : key_q;
        if (pop) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            hold_q      <= '0;
            key_q       <= 8'h00;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            key_q       <= key_d;
            key_valid_q <= pop;
            overrun_q   <= overrun_d;
        end
    end

    // Storage needs no reset: the count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_data;
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keypad_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keypad_rx
// Purpose  : Directed, table-driven bench for ps2_keypad_rx (two hold settings).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keypad_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] key_a, key_b;
    logic       kv_a, kv_b, fe_a, fe_b, ov_a, ov_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_fall_cyc = 0;

    int fe_a_cnt = 0, fe_b_cnt = 0, ov_a_cnt = 0, ov_b_cnt = 0;
    int fe_a_cyc = 0;
    logic [7:0] kva_q[$], kvb_q[$];
    int         kva_c[$], kvb_c[$];

    always #5 clk = ~clk;

    ps2_keypad_rx #(.MIN_HOLD(8), .TIMEOUT(50)) dut_a (
        .clk(clk), .reset(rst), .ps2_clk(ps2c), .ps2_data(ps2d),
        .key(key_a), .key_valid(kv_a), .frame_err(fe_a), .overrun(ov_a)
    );

    ps2_keypad_rx #(.MIN_HOLD(1000), .TIMEOUT(50)) dut_b (
        .clk(clk), .reset(rst), .ps2_clk(ps2c), .ps2_data(ps2d),
        .key(key_b), .key_valid(kv_b), .frame_err(fe_b), .overrun(ov_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (kv_a) begin kva_q.push_back(key_a); kva_c.push_back(cyc); end
        if (kv_b) begin kvb_q.push_back(key_b); kvb_c.push_back(cyc); end
        if (fe_a) begin fe_a_cnt <= fe_a_cnt + 1; fe_a_cyc <= cyc; end
        if (fe_b) fe_b_cnt <= fe_b_cnt + 1;
        if (ov_a) ov_a_cnt <= ov_a_cnt + 1;
        if (ov_b) ov_b_cnt <= ov_b_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // h = half ps2 clock period in clk cycles
    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs,
                              input int nbits, input int h);
        logic [10:0] fr;
        fr = {~bs, (~^d) ^ bp, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            repeat (h / 2) @(negedge clk);
            ps2c = 1'b0;
            last_fall_cyc = cyc;
            repeat (h) @(negedge clk);
            ps2c = 1'b1;
            repeat (h - h / 2) @(negedge clk);
        end
        ps2d = 1'b1;
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        logic [7:0] exp_key;
        int         exp_fe;
        int         exp_kv;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int fe0, kv0, ov0, n0;

        vecs[0]  = '{8'h16, 1'b1, 1'b0, 8'h00, 1, 0};
        vecs[1]  = '{8'h1E, 1'b0, 1'b0, 8'h1E, 0, 1};
        vecs[2]  = '{8'hE0, 1'b0, 1'b0, 8'h1E, 0, 0};
        vecs[3]  = '{8'h75, 1'b0, 1'b0, 8'h75, 0, 1};
        vecs[4]  = '{8'h29, 1'b0, 1'b1, 8'h75, 1, 0};
        vecs[5]  = '{8'hF0, 1'b1, 1'b0, 8'h75, 1, 0};
        vecs[6]  = '{8'h12, 1'b0, 1'b0, 8'h12, 0, 1};
        vecs[7]  = '{8'hE0, 1'b0, 1'b0, 8'h12, 0, 0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b0, 8'hF0, 0, 1};
        vecs[9]  = '{8'h6B, 1'b0, 1'b0, 8'h00, 0, 1};
        vecs[10] = '{8'h6B, 1'b0, 1'b0, 8'h6B, 0, 1};
        vecs[11] = '{8'h6B, 1'b0, 1'b0, 8'h6B, 0, 1};

        rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
        wait_cyc(5);
        chk("reset_key", key_a, 8'h00);
        chk("reset_kv",  kv_a,  0);
        chk("reset_fe",  fe_a,  0);
        chk("reset_ov",  ov_a,  0);
        rst = 1'b0;
        wait_cyc(10);

        // Single good frame: key valid 5 clk after the stop-bit ps2 fall
        // (2 sync + 1 detect/strobe + enqueue + pop)
        send_frame(8'h70, 0, 0, 11, 20);
        wait_cyc(20);
        chk("good_kv_count", kva_q.size(), 1);
        chk("good_key", key_a, 8'h70);
        if (kva_c.size() > 0) chk("good_latency", kva_c[0] - last_fall_cyc, 5);

        // Back-to-back make / break / make
        kva_q.delete(); kva_c.delete();
        ov0 = ov_a_cnt;
        send_frame(8'h70, 0, 0, 11, 20);
        send_frame(8'hF0, 0, 0, 11, 20);
        send_frame(8'h70, 0, 0, 11, 20);
        wait_cyc(40);
        chk("seq_count", kva_q.size(), 3);
        if (kva_q.size() == 3) begin
            chk("seq_k0", kva_q[0], 8'h70);
            chk("seq_k1", kva_q[1], 8'hF0);
            chk("seq_k2", kva_q[2], 8'h00);
            chk("seq_hold01", int'(kva_c[1] - kva_c[0] >= 8), 1);
            chk("seq_hold12", int'(kva_c[2] - kva_c[1] >= 8), 1);
        end
        chk("seq_overrun", ov_a_cnt - ov0, 0);

        for (int i = 0; i < 12; i++) begin
            fe0 = fe_a_cnt;
            kv0 = kva_q.size();
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, 11, 20);
            wait_cyc(30);
            chk($sformatf("vec%0d_key", i), key_a, vecs[i].exp_key);
            chk($sformatf("vec%0d_fe", i), fe_a_cnt - fe0, vecs[i].exp_fe);
            chk($sformatf("vec%0d_kv", i), kva_q.size() - kv0, vecs[i].exp_kv);
        end

        // Start bit of 1 is rejected in IDLE
        fe0 = fe_a_cnt; kv0 = kva_q.size();
        ps2d = 1'b1;
        wait_cyc(10); ps2c = 1'b0; wait_cyc(20); ps2c = 1'b1; wait_cyc(30);
        chk("badstart_fe", fe_a_cnt - fe0, 1);
        chk("badstart_kv", kva_q.size() - kv0, 0);

        // Stall after 5 bits: error 53 clk after last fall (3 sync/detect + 50)
        fe0 = fe_a_cnt;
        send_frame(8'h1E, 0, 0, 5, 20);
        wait_cyc(60);
        chk("timeout_fe", fe_a_cnt - fe0, 1);
        chk("timeout_when", fe_a_cyc - last_fall_cyc, 53);
        send_frame(8'h1E, 0, 0, 11, 20);
        wait_cyc(30);
        chk("after_timeout_key", key_a, 8'h1E);
        chk("after_timeout_fe", fe_a_cnt - fe0, 1);

        // FIFO overrun with long hold
        rst = 1'b1; wait_cyc(3); rst = 1'b0; wait_cyc(5);
        kvb_q.delete(); kvb_c.delete();
        ov0 = ov_b_cnt;
        send_frame(8'h11, 0, 0, 11, 5);
        send_frame(8'h22, 0, 0, 11, 5);
        send_frame(8'h33, 0, 0, 11, 5);
        send_frame(8'h44, 0, 0, 11, 5);
        send_frame(8'h55, 0, 0, 11, 5);
        send_frame(8'h66, 0, 0, 11, 5);
        wait_cyc(20);
        chk("ovr_pulse", ov_b_cnt - ov0, 1);
        chk("ovr_first_key", key_b, 8'h11);
        wait_cyc(4500);
        chk("ovr_count", kvb_q.size(), 5);
        if (kvb_q.size() == 5) begin
            for (int i = 0; i < 5; i++)
                chk($sformatf("ovr_k%0d", i), kvb_q[i], (i + 1) * 8'h11);
            for (int i = 1; i < 5; i++)
                chk($sformatf("ovr_gap%0d", i), kvb_c[i] - kvb_c[i-1], 1000);
        end
        chk("ovr_final_key", key_b, 8'h55);

        // Reset mid-FIFO and mid-frame
        send_frame(8'h21, 0, 0, 11, 5);
        send_frame(8'h32, 0, 0, 11, 5);
        send_frame(8'h43, 0, 0, 11, 5);
        send_frame(8'h54, 0, 0, 4, 5);
        ps2c = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_async_key_b", key_b, 8'h00);
        chk("rst_async_kv_b", kv_b, 0);
        wait_cyc(3);
        ps2c = 1'b1;
        rst = 1'b0;
        kva_q.delete(); kvb_q.delete(); kva_c.delete(); kvb_c.delete();
        n0 = fe_b_cnt;
        wait_cyc(1500);
        chk("post_rst_kv_b", kvb_q.size(), 0);
        chk("post_rst_kv_a", kva_q.size(), 0);
        chk("post_rst_key_b", key_b, 8'h00);
        chk("post_rst_fe_b", fe_b_cnt - n0, 0);
        send_frame(8'h4A, 0, 0, 11, 20);
        wait_cyc(30);
        chk("post_rst_new_b", key_b, 8'h4A);
        chk("post_rst_new_a", key_a, 8'h4A);
        chk("post_rst_kvcnt_b", kvb_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
